// File: rtl/tff_seq_ctrl_if.sv
// Handshake/bus bundle for the sequenced T flip-flop controller.
// The master side issues control commands; the slave side (the controller)
// returns the toggle mask, bank state and status flags.
interface tff_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, pause, dir, mode, limit,
        input  t_vec, count, busy, tc, done
    );

    modport slave (
        input  start, stop, pause, dir, mode, limit,
        output t_vec, count, busy, tc, done
    );
endinterface

// File: rtl/tff_seq_ctrl.sv
// Sequenced T flip-flop bank controller.
// A bank of WIDTH T flip-flops is stepped up or down one count per cycle by
// computing per-bit toggle enables; every change of the bank (load, step,
// reload, clear) goes through the same count ^ t_vec update.
module tff_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    tff_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] dn_mask;
    logic             dir_q;
    logic             mode_q;
    logic             done_q;
    logic             done_nxt;
    logic             latch_en;
    logic             at_end;

    // Increment toggles bit i when all lower bits are 1; decrement when all
    // lower bits are 0. Bit 0 always toggles on a normal step.
    assign up_mask[0] = 1'b1;
    assign dn_mask[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_mask
        assign up_mask[i] = &count_q[i-1:0];
        assign dn_mask[i] = &(~count_q[i-1:0]);
    end

    // Up runs end at the latched limit and restart from 0; down runs the
    // other way round, so the reload path also covers the all-ones wrap.
    assign end_val   = dir_q ? '0 : limit_q;
    assign start_val = dir_q ? limit_q : '0;
    assign at_end    = (count_q == end_val);

    // Next-state and toggle-mask decode; reset drives t_vec = count so the
    // bank clears through the ordinary toggle path.
    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        done_nxt  = 1'b0;
        latch_en  = 1'b0;
        if (!rst) begin
            t_vec     = count_q;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        latch_en  = 1'b1;
                        t_vec     = count_q ^ (bus.dir ? bus.limit : '0);
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        t_vec     = count_q;
                        state_nxt = IDLE;
                    end else if (bus.pause) begin
                        state_nxt = HOLD;
                    end else if (at_end) begin
                        done_nxt = 1'b1;
                        if (mode_q) begin
                            t_vec = count_q ^ start_val;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        t_vec = dir_q ? dn_mask : up_mask;
                    end
                end
                HOLD: begin
                    if (bus.stop) begin
                        t_vec     = count_q;
                        state_nxt = IDLE;
                    end else if (!bus.pause) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register and the registered done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Sequence parameters are captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            limit_q <= '0;
        end else if (latch_en) begin
            dir_q   <= bus.dir;
            mode_q  <= bus.mode;
            limit_q <= bus.limit;
        end
    end

    // The T flip-flop bank itself: the toggle mask is its only write path.
    always_ff @(posedge clk) begin
        count_q <= count_q ^ t_vec;
    end

    assign bus.t_vec = t_vec;
    assign bus.count = count_q;
    assign bus.busy  = (state == RUN) || (state == HOLD);
    assign bus.tc    = rst && (state == RUN) && at_end;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Testbench for tff_seq_ctrl: directed scenarios plus randomized traffic,
// with an arithmetic reference model feeding a per-cycle scoreboard.
module tb_tff_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_DONE = 3;

    typedef struct {
        int count;
        int t_vec;
        bit busy;
        bit tc;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tff_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    tff_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   num_checks = 0;
    int   num_fails  = 0;

    // Reference model state: plain integers, stepped by arithmetic.
    int   m_count = 0;
    int   m_phase = PH_IDLE;
    bit   m_dir   = 1'b0;
    bit   m_mode  = 1'b0;
    int   m_limit = 0;
    bit   m_done  = 1'b0;

    int   prev_count = 0;
    int   prev_tvec  = 0;
    bit   have_prev  = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        num_checks++;
        if (act != exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict that cycle's outputs, queue them,
    // then advance the model across the coming clock edge.
    task automatic applyStimulus(input bit r, input bit st, input bit sp, input bit pa,
                                 input bit d, input bit m, input int lim);
        int   nxt;
        int   nphase;
        bit   ndone;
        int   endv;
        int   startv;
        int   lim_m;
        exp_t e;
        @(posedge clk);
        #1;
        lim_m     = lim & MASK;
        rst       = r;
        bus.start = st;
        bus.stop  = sp;
        bus.pause = pa;
        bus.dir   = d;
        bus.mode  = m;
        bus.limit = lim_m[WIDTH-1:0];

        endv   = m_dir ? 0 : m_limit;
        startv = m_dir ? m_limit : 0;
        e.count = m_count;
        e.busy  = (m_phase == PH_RUN) || (m_phase == PH_HOLD);
        e.done  = m_done;
        e.tc    = r && (m_phase == PH_RUN) && (m_count == endv);

        nxt    = m_count;
        nphase = m_phase;
        ndone  = 1'b0;
        if (!r) begin
            nxt     = 0;
            nphase  = PH_IDLE;
            m_dir   = 1'b0;
            m_mode  = 1'b0;
            m_limit = 0;
        end else if (m_phase == PH_IDLE) begin
            if (st) begin
                m_dir   = d;
                m_mode  = m;
                m_limit = lim_m;
                nxt     = d ? lim_m : 0;
                nphase  = PH_RUN;
            end
        end else if (m_phase == PH_RUN) begin
            if (sp) begin
                nxt    = 0;
                nphase = PH_IDLE;
            end else if (pa) begin
                nphase = PH_HOLD;
            end else if (m_count == endv) begin
                ndone = 1'b1;
                if (m_mode) nxt = startv;
                else        nphase = PH_DONE;
            end else begin
                nxt = m_dir ? ((m_count - 1) & MASK) : ((m_count + 1) & MASK);
            end
        end else if (m_phase == PH_HOLD) begin
            if (sp) begin
                nxt    = 0;
                nphase = PH_IDLE;
            end else if (!pa) begin
                nphase = PH_RUN;
            end
        end else begin
            nphase = PH_IDLE;
        end
        e.t_vec = m_count ^ nxt;
        exp_q.push_back(e);
        m_count = nxt;
        m_phase = nphase;
        m_done  = ndone;
    endtask

    // One cycle with the given controls; the latched-only inputs carry junk.
    task automatic step(input bit st, input bit sp, input bit pa);
        applyStimulus(1'b1, st, sp, pa, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_seq(input bit d, input bit m, input int lim);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, d, m, lim);
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: pop the expected outputs for every driven cycle and compare,
    // and check the T-FF law across consecutive cycles.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("count", int'(bus.count), mon_e.count);
            checkOutput("t_vec", int'(bus.t_vec), mon_e.t_vec);
            checkOutput("busy",  int'(bus.busy),  int'(mon_e.busy));
            checkOutput("tc",    int'(bus.tc),    int'(mon_e.tc));
            checkOutput("done",  int'(bus.done),  int'(mon_e.done));
            if (have_prev) checkOutput("xor_law", int'(bus.count), prev_count ^ prev_tvec);
            prev_count = int'(bus.count);
            prev_tvec  = int'(bus.t_vec);
            have_prev  = 1'b1;
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        bus.dir   = 1'b0;
        bus.mode  = 1'b0;
        bus.limit = '0;

        $display("[TB] reset");
        reset_cycles(3);

        $display("[TB] up one-shot, limit 5");
        start_seq(1'b0, 1'b0, 5);
        run_steps(10);

        $display("[TB] down periodic, limit 3");
        start_seq(1'b1, 1'b1, 3);
        run_steps(13);
        step(1'b0, 1'b1, 1'b0);
        run_steps(2);

        $display("[TB] pause and stop, up limit 10");
        start_seq(1'b0, 1'b0, 10);
        run_steps(4);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        run_steps(4);
        step(1'b0, 1'b1, 1'b0);
        run_steps(3);

        $display("[TB] limit 0 one-shot and periodic");
        start_seq(1'b0, 1'b0, 0);
        run_steps(4);
        start_seq(1'b1, 1'b1, 0);
        run_steps(4);
        step(1'b0, 1'b1, 1'b0);
        run_steps(1);

        $display("[TB] limit 255 periodic up with stray starts");
        start_seq(1'b0, 1'b1, 255);
        for (int k = 0; k < 262; k++) step(1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run_steps(1);

        $display("[TB] reset mid-run");
        start_seq(1'b0, 1'b0, 10);
        run_steps(7);
        reset_cycles(1);
        start_seq(1'b0, 1'b0, 3);
        run_steps(7);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2000; k++) begin
            bit r, st, sp, pa, d, m;
            int lim;
            r   = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            sp  = ($urandom_range(0, 29) == 0);
            pa  = ($urandom_range(0, 9) == 0);
            d   = 1'($urandom_range(0, 1));
            m   = 1'($urandom_range(0, 1));
            lim = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 12));
            applyStimulus(r, st, sp, pa, d, m, lim);
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
